// File: rtl/hb_mc_axil_host_bridge_if.sv
// AXI-Lite (32-bit data) bus bundle between the shell OCL master and the host bridge.
interface hb_mc_axil_host_bridge_if #(
  parameter int unsigned addr_width_p = 32
);
  logic [addr_width_p-1:0] awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [addr_width_p-1:0] araddr;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/hb_mc_axil_host_bridge.sv
// AXI-Lite to 128-bit host packet bridge: host assembles TX packets word by word,
// drains RX packets word by word, and polls FIFO levels through status registers.
module hb_mc_axil_host_bridge #(
  parameter int unsigned axil_addr_width_p = 32,
  parameter int unsigned fifo_els_p        = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  hb_mc_axil_host_bridge_if.slave s_axil,
  output logic                    tx_v_o,
  output logic [127:0]            tx_data_o,
  input  logic                    tx_ready_i,
  input  logic                    rx_v_i,
  input  logic [127:0]            rx_data_i,
  output logic                    rx_ready_o
);

  localparam int unsigned data_w  = 32;
  localparam int unsigned words_p = 4;
  localparam int unsigned ptr_w   = $clog2(fifo_els_p);
  localparam int unsigned cnt_w   = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(fifo_els_p);

  localparam logic [3:0] reg_tx_word  = 4'h0;
  localparam logic [3:0] reg_tx_vac   = 4'h1;
  localparam logic [3:0] reg_rx_avail = 4'h2;
  localparam logic [3:0] reg_rx_word  = 4'h3;
  localparam logic [3:0] reg_tx_cnt   = 4'h4;
  localparam logic [3:0] reg_abort    = 4'h5;

  localparam logic [1:0] resp_okay   = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;
  localparam logic [1:0] resp_decerr = 2'b11;

  typedef logic [words_p-1:0][data_w-1:0] pkt_t;

  logic [axil_addr_width_p-1:0] aw_addr;
  logic [axil_addr_width_p-1:0] ar_addr;

  pkt_t             tx_mem [fifo_els_p];
  pkt_t             rx_mem [fifo_els_p];
  logic [2:0][data_w-1:0] tx_part;

  logic [ptr_w-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [cnt_w-1:0] tx_count, rx_count, tx_count_next, rx_count_next;
  logic [1:0]       tx_cnt, tx_cnt_next, rx_idx, rx_idx_next;

  logic              bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q, bresp_d, rresp_d;
  logic [data_w-1:0] rdata_q, rdata_d;

  logic wr_fire, rd_fire, tx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, part_we;
  logic unused_bits;

  assign aw_addr     = s_axil.awaddr;
  assign ar_addr     = s_axil.araddr;
  assign unused_bits = ^{aw_addr, ar_addr, s_axil.wstrb};

  assign s_axil.awready = wr_fire;
  assign s_axil.wready  = wr_fire;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = ~rvalid_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  assign tx_data_o     = tx_mem[tx_rd_ptr];
  assign tx_pop        = tx_v_o & tx_ready_i;
  assign rx_push       = rx_v_i & rx_ready_o;
  assign tx_count_next = tx_count + cnt_w'(tx_push) - cnt_w'(tx_pop);
  assign rx_count_next = rx_count + cnt_w'(rx_push) - cnt_w'(rx_pop);

  // Write decode: word assembly, full-FIFO rejection on the last word, abort.
  always_comb begin
    wr_fire     = s_axil.awvalid & s_axil.wvalid & ~bvalid_q;
    tx_full     = (tx_count == full_cnt);
    tx_push     = 1'b0;
    part_we     = 1'b0;
    tx_cnt_next = tx_cnt;
    bresp_d     = resp_decerr;
    case (aw_addr[5:2])
      reg_tx_word: begin
        if (tx_cnt == 2'd3) begin
          if (tx_full) begin
            bresp_d = resp_slverr;
          end else begin
            bresp_d = resp_okay;
            tx_push = wr_fire;
            if (wr_fire) tx_cnt_next = 2'd0;
          end
        end else begin
          bresp_d = resp_okay;
          part_we = wr_fire;
          if (wr_fire) tx_cnt_next = tx_cnt + 2'd1;
        end
      end
      reg_abort: begin
        bresp_d = resp_okay;
        if (wr_fire) tx_cnt_next = 2'd0;
      end
      default: ;
    endcase
  end

  // Read decode: status registers use pre-update counts; RX word read advances the head.
  always_comb begin
    rd_fire     = s_axil.arvalid & ~rvalid_q;
    rx_empty    = (rx_count == '0);
    rx_pop      = 1'b0;
    rx_idx_next = rx_idx;
    rdata_d     = '0;
    rresp_d     = resp_decerr;
    case (ar_addr[5:2])
      reg_tx_vac: begin
        rdata_d = data_w'(full_cnt - tx_count);
        rresp_d = resp_okay;
      end
      reg_rx_avail: begin
        rdata_d = data_w'({rx_count, 2'b00}) - data_w'(rx_idx);
        rresp_d = resp_okay;
      end
      reg_rx_word: begin
        if (rx_empty) begin
          rresp_d = resp_slverr;
        end else begin
          rdata_d = rx_mem[rx_rd_ptr][rx_idx];
          rresp_d = resp_okay;
          if (rd_fire) begin
            rx_idx_next = rx_idx + 2'd1;
            rx_pop      = (rx_idx == 2'd3);
          end
        end
      end
      reg_tx_cnt: begin
        rdata_d = data_w'(tx_cnt);
        rresp_d = resp_okay;
      end
      default: ;
    endcase
  end

  // Control state: response channels, FIFO pointers/counts, registered flow-control outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      tx_cnt     <= '0;
      rx_idx     <= '0;
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_count   <= '0;
      tx_v_o     <= 1'b0;
      rx_ready_o <= 1'b0;
    end else begin
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (s_axil.bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (s_axil.rready) begin
        rvalid_q <= 1'b0;
      end
      tx_cnt <= tx_cnt_next;
      rx_idx <= rx_idx_next;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + ptr_w'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + ptr_w'(1);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + ptr_w'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + ptr_w'(1);
      tx_count   <= tx_count_next;
      rx_count   <= rx_count_next;
      tx_v_o     <= (tx_count_next != '0);
      rx_ready_o <= (rx_count_next != full_cnt);
    end
  end

  // Data storage: partial TX words and FIFO payloads need no reset.
  always_ff @(posedge clk_i) begin
    if (part_we) tx_part[tx_cnt] <= s_axil.wdata;
    if (tx_push) tx_mem[tx_wr_ptr] <= {s_axil.wdata, tx_part[2], tx_part[1], tx_part[0]};
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data_i;
  end

endmodule
